// File: rtl/insn_fetch_queue.sv
// Instruction fetch stage: one outstanding word read at a time, a DEPTH-entry FIFO of
// {insn, pc} toward the core, and a redirect that flushes the FIFO and restarts fetch.
module insn_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        insn_ready
);

  localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] EMPTY = {(PW+1){1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic          req_s;
  logic [31:0]   addr_s;
  logic          push_s, pop_s;
  logic [PW-1:0] head_r, head_s, tail_r, tail_s;
  logic [PW:0]   count_r, count_s;
  logic          valid_s;
  logic [31:0]   insn_s, insn_pc_s;
  logic [31:0]   buf_insn_r [DEPTH];
  logic [31:0]   buf_pc_r   [DEPTH];

  // Fetch FSM: issue, wait for ack, or drain a request made stale by a redirect.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_s      = mem_req;
    push_s     = 1'b0;
    addr_s     = mem_addr;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          fetch_pc_s = redirect_pc;
        end else if (count_r < FULL) begin
          state_s = WAIT;
          req_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_s = redirect_pc;
          if (mem_ack) begin
            state_s = IDLE;
            req_s   = 1'b0;
          end else begin
            state_s = DRAIN;
          end
        end else if (mem_ack) begin
          push_s     = 1'b1;
          fetch_pc_s = mem_addr + 32'd1;
          state_s    = IDLE;
          req_s      = 1'b0;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        if (redirect) begin
          fetch_pc_s = redirect_pc;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
        if (mem_ack) begin
          state_s = IDLE;
          req_s   = 1'b0;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
    // While no request is held, mem_addr follows the next fetch address.
    if ((state_r == IDLE) || (state_s == IDLE)) begin
      addr_s = fetch_pc_s;
    end else begin
      addr_s = mem_addr;
    end
  end

  // FIFO pointer/count update and next head view for the registered core outputs.
  always_comb begin
    pop_s     = (count_r != EMPTY) && insn_ready && !redirect;
    head_s    = head_r;
    tail_s    = tail_r;
    count_s   = count_r;
    insn_s    = insn;
    insn_pc_s = insn_pc;
    if (redirect) begin
      head_s  = {PW{1'b0}};
      tail_s  = {PW{1'b0}};
      count_s = EMPTY;
    end else begin
      head_s  = head_r + PW'(pop_s);
      tail_s  = tail_r + PW'(push_s);
      count_s = count_r + (PW+1)'(push_s) - (PW+1)'(pop_s);
    end
    valid_s = (count_s != EMPTY);
    // A word pushed into an otherwise empty FIFO becomes the head directly.
    if (valid_s) begin
      if (push_s && (count_r == (PW+1)'(pop_s))) begin
        insn_s    = mem_data;
        insn_pc_s = mem_addr;
      end else begin
        insn_s    = buf_insn_r[head_s];
        insn_pc_s = buf_pc_r[head_s];
      end
    end else begin
      insn_s    = insn;
      insn_pc_s = insn_pc;
    end
  end

  // Control state and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= EMPTY;
      insn_valid <= 1'b0;
      insn       <= 32'h0000_0000;
      insn_pc    <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      mem_req    <= req_s;
      mem_addr   <= addr_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      count_r    <= count_s;
      insn_valid <= valid_s;
      insn       <= insn_s;
      insn_pc    <= insn_pc_s;
    end
  end

  // FIFO storage; contents past count are never observed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      buf_insn_r[tail_r] <= mem_data;
      buf_pc_r[tail_r]   <= mem_addr;
    end else begin
      buf_insn_r[tail_r] <= buf_insn_r[tail_r];
      buf_pc_r[tail_r]   <= buf_pc_r[tail_r];
    end
  end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of the fetch stage.
module tb_insn_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] MAIN_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, mem_ack, insn_ready;
  logic [31:0] redirect_pc, mem_data;
  logic        mem_req, insn_valid;
  logic [31:0] mem_addr, insn, insn_pc;

  logic        w_rst, w_ack, w_ready;
  logic [31:0] w_data;
  logic        w_mem_req, w_insn_valid;
  logic [31:0] w_mem_addr, w_insn, w_insn_pc;

  insn_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(MAIN_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready)
  );

  insn_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst(w_rst), .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_ack), .mem_data(w_data),
    .insn_valid(w_insn_valid), .insn(w_insn), .insn_pc(w_insn_pc), .insn_ready(w_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue, plus one in-flight request that may be stale.
  typedef struct packed { logic [31:0] w; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  bit          m_busy  = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_fetch = MAIN_PC;
  logic [31:0] m_req_addr = MAIN_PC;

  task automatic model_edge();
    int   sz;
    bit   do_pop;
    ent_t e;
    if (rst) begin
      q.delete();
      m_fetch = MAIN_PC;
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else if (redirect) begin
      q.delete();
      m_fetch = redirect_pc;
      if (m_busy && mem_ack) begin
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end
    end else begin
      sz     = q.size();
      do_pop = (sz > 0) && insn_ready;
      if (m_busy) begin
        if (mem_ack) begin
          if (!m_stale) begin
            e.w  = mem_data;
            e.pc = m_req_addr;
            q.push_back(e);
            m_fetch = m_req_addr + 32'd1;
          end
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end
      end else if (sz < DEPTH) begin
        m_busy     = 1'b1;
        m_req_addr = m_fetch;
      end
      if (do_pop) void'(q.pop_front());
    end
  endtask

  task automatic model_check();
    check_value("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) check_value("mem_addr", mem_addr, m_req_addr);
    check_value("insn_valid", 32'(insn_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_value("insn", insn, q[0].w);
      check_value("insn_pc", insn_pc, q[0].pc);
    end
  endtask

  int          lat = 1;
  int          age = 0;
  bit          prev_req = 1'b0;
  logic [31:0] issue_log[$];

  // One clock: drive inputs, advance model at the edge, check on the falling edge.
  // ack_mode: 0 no ack, 1 ack, 2 ack after lat cycles of mem_req, 3 random.
  task automatic tick(input bit t_rst, input bit t_ready, input bit t_redir,
                      input logic [31:0] t_rpc, input int ack_mode);
    bit a;
    if (!mem_req) age = 0;
    case (ack_mode)
      0:       a = 1'b0;
      1:       a = 1'b1;
      2:       a = mem_req && (age >= lat - 1);
      default: a = 1'($urandom_range(0, 1));
    endcase
    rst         = t_rst;
    insn_ready  = t_ready;
    redirect    = t_redir;
    redirect_pc = t_rpc;
    mem_ack     = a;
    mem_data    = $urandom;
    if (mem_req && !a) age++;
    else age = 0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
    if (mem_req && !prev_req) issue_log.push_back(mem_addr);
    prev_req = mem_req;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_ack = 1'b0; mem_data = 32'h0;
    insn_ready = 1'b0;
    w_rst = 1'b1; w_ack = 1'b0; w_ready = 1'b0; w_data = 32'h0;
    @(negedge clk);

    // Reset state, then sequential fetch with single-cycle memory.
    lat = 1;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("rst_mem_req", 32'(mem_req), 32'd0);
    check_value("rst_mem_addr", mem_addr, MAIN_PC);
    check_value("rst_valid", 32'(insn_valid), 32'd0);
    check_value("rst_insn", insn, 32'd0);
    check_value("rst_insn_pc", insn_pc, 32'd0);
    issue_log.delete();
    tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("first_req", 32'(mem_req), 32'd1);
    check_value("valid_early", 32'(insn_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("first_valid", 32'(insn_valid), 32'd1);
    check_value("first_pc", insn_pc, 32'd0);
    repeat (6) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("seq_issues", 32'(issue_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_value("seq_addr", issue_log[i], 32'(i));

    // Backpressure: four requests fill the FIFO, then fetch stops until drained.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
    issue_log.delete();
    repeat (14) tick(1'b0, 1'b0, 1'b0, 32'h0, 2);
    check_value("bp_issues", 32'(issue_log.size()), 32'd4);
    check_value("bp_req_off", 32'(mem_req), 32'd0);
    check_value("bp_head_pc", insn_pc, 32'd0);
    issue_log.delete();
    repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("bp_resume", issue_log[0], 32'd4);

    // Redirect while idle with two words buffered.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 20 && !(q.size() == 2 && !mem_req); i++)
      tick(1'b0, 1'b0, 1'b0, 32'h0, 2);
    check_value("ri_setup", 32'(q.size()), 32'd2);
    tick(1'b0, 1'b0, 1'b1, 32'h100, 0);
    check_value("ri_valid", 32'(insn_valid), 32'd0);
    check_value("ri_addr", mem_addr, 32'h100);
    for (int i = 0; i < 10 && !insn_valid; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("ri_first_pc", insn_pc, 32'h100);

    // Redirect during a 3-cycle memory wait.
    lat = 3;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    issue_log.delete();
    tick(1'b0, 1'b1, 1'b1, 32'h40, 0);
    check_value("rw_drain_req", 32'(mem_req), 32'd1);
    check_value("rw_valid", 32'(insn_valid), 32'd0);
    for (int i = 0; i < 10 && issue_log.size() == 0; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("rw_next_addr", issue_log[0], 32'h40);
    repeat (8) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);

    // Redirect coincident with ack, then two redirects during a drain.
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    issue_log.delete();
    tick(1'b0, 1'b1, 1'b1, 32'h20, 1);
    check_value("rc_valid", 32'(insn_valid), 32'd0);
    check_value("rc_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 10 && issue_log.size() == 0; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("rc_next_addr", issue_log[0], 32'h20);
    tick(1'b0, 1'b1, 1'b1, 32'h40, 0);
    tick(1'b0, 1'b1, 1'b1, 32'h80, 0);
    check_value("rd_hold_addr", mem_addr, 32'h20);
    issue_log.delete();
    for (int i = 0; i < 10 && issue_log.size() == 0; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 2);
    check_value("rd_next_addr", issue_log[0], 32'h80);
    for (int i = 0; i < 10 && !insn_valid; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 2);
    check_value("rd_first_pc", insn_pc, 32'h80);

    // Reset while a request is in flight; a later ack must be ignored.
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("rf_req", 32'(mem_req), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1);
    check_value("rf_valid", 32'(insn_valid), 32'd0);
    check_value("rf_restart", mem_addr, MAIN_PC);

    // Address wrap on the second instance, plus its reset-in-flight case.
    w_rst = 1'b1; w_ready = 1'b1; w_ack = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_rst_addr", w_mem_addr, WRAP_PC);
    check_value("w_rst_valid", 32'(w_insn_valid), 32'd0);
    w_rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_req0", w_mem_addr, 32'hFFFF_FFFF);
    w_ack = 1'b1; w_data = 32'hA5A5_0001;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_pc0", w_insn_pc, 32'hFFFF_FFFF);
    check_value("w_insn0", w_insn, 32'hA5A5_0001);
    w_ack = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_req1_on", 32'(w_mem_req), 32'd1);
    check_value("w_req1", w_mem_addr, 32'h0000_0000);
    w_ack = 1'b1; w_data = 32'hA5A5_0002;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_pc1", w_insn_pc, 32'h0000_0000);
    w_ack = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    w_rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_rf_req", 32'(w_mem_req), 32'd0);
    w_rst = 1'b0; w_ack = 1'b1; w_data = 32'hDEAD_BEEF;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_rf_valid", 32'(w_insn_valid), 32'd0);
    check_value("w_rf_addr", w_mem_addr, WRAP_PC);
    w_data = 32'hA5A5_0003;
    tick(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check_value("w_rf_pc", w_insn_pc, WRAP_PC);
    check_value("w_rf_insn", w_insn, 32'hA5A5_0003);
    w_ack = 1'b0; w_rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 3))) : $urandom;
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), rpc, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
